// File: rtl/bcd_seg_scanner_if.sv
// Bundle between the score logic and the seven-segment scanner.
//   enable      : 1 = scan and drive, 0 = display dark with counters held
//   bcd[0:3]    : BCD digits, [0] = ones .. [3] = thousands
//   seg         : segments {g,f,e,d,c,b,a}
//   an          : digit anodes, an[k] selects digit k
//   frame_start : one-cycle pulse on the cycle the shadow digits load
// master = digit source / display consumer, slave = scanner.
interface bcd_seg_scanner_if;
    logic       enable;
    logic [3:0] bcd [4];
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    modport master (output enable, bcd, input seg, an, frame_start);
    modport slave  (input enable, bcd, output seg, an, frame_start);
endinterface

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment driver for the score display.
// Digits are captured once per frame into a shadow copy so the display never
// tears, leading zeros are blanked, and each slot starts with a dark guard
// interval to suppress ghosting.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : bcd_seg_scanner_if.slave (enable, bcd in; seg, an, frame_start out)
module bcd_seg_scanner #(
    parameter int unsigned REFRESH_DIV   = 100_000,
    parameter int unsigned GUARD_CYCLES  = 1_000,
    parameter bit          BLANK_LEADING = 1'b1,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_seg_scanner_if.slave   bus
);
    localparam int unsigned CW      = $clog2(REFRESH_DIV);
    localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shadow [4];
    logic          tick;

    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_code;
    logic [3:0]    an_code;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign tick = (cnt == CW'(REFRESH_DIV - 1));

    always_comb begin
        digit = shadow[idx];

        // Digit idx is a leading zero when it and every more-significant
        // digit are zero; the ones digit is always shown.
        blank = 1'b0;
        if (BLANK_LEADING && idx != 2'd0) begin
            blank = 1'b1;
            for (int unsigned k = 1; k < 4; k++) begin
                if (k >= 32'(idx) && shadow[k] != 4'd0)
                    blank = 1'b0;
            end
        end

        case (digit)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h40;   // invalid BCD shows a dash
        endcase
        if (blank)
            seg_code = '0;

        // seg keeps showing the digit during the guard; only the anode is held off.
        an_code = '0;
        if (!blank && 32'(cnt) >= GUARD_CYCLES)
            an_code[idx] = 1'b1;

        seg_next = ACTIVE_LOW ? ~seg_code : seg_code;
        an_next  = ACTIVE_LOW ? ~an_code  : an_code;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt             <= '0;
            idx             <= '0;
            shadow          <= '{default: '0};
            bus.frame_start <= 1'b0;
            bus.seg         <= SEG_OFF;
            bus.an          <= AN_OFF;
        end else if (bus.enable) begin
            cnt             <= tick ? '0 : cnt + CW'(1);
            bus.frame_start <= 1'b0;
            if (tick) begin
                idx <= idx + 2'd1;   // wraps 3 -> 0 on the frame boundary
                if (idx == 2'd3) begin
                    shadow          <= bus.bcd;
                    bus.frame_start <= 1'b1;
                end
            end
            bus.seg <= seg_next;
            bus.an  <= an_next;
        end else begin
            bus.frame_start <= 1'b0;
            bus.seg         <= SEG_OFF;
            bus.an          <= AN_OFF;
        end
    end
endmodule
